// File: rtl/pwm_fade_pkg.sv
// Shared types and helpers for the multi-channel PWM fader.
//   fade_mode_t : runtime fade pattern (hold / triangle / sawtooth)
//   fade_dir_t  : per-channel ramp direction
//   init_duty   : phase-spread reset duty for channel i, rounded down to a STEP multiple
package pwm_fade_pkg;

    typedef enum logic [1:0] {
        FADE_HOLD = 2'b00,
        FADE_TRI  = 2'b01,
        FADE_SAW  = 2'b10
    } fade_mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } fade_dir_t;

    function automatic int init_duty(input int i, input int channels,
                                     input int pwm_interval, input int step);
        return ((i * pwm_interval / channels) / step) * step;
    endfunction

endpackage

// File: rtl/pwm_fade_multi_channel.sv
// One fader channel: duty/direction state, optional square-law gamma and the
// registered PWM compare.
// Optional feature macro: FADE_GAMMA_EN (square-law brightness mapping).
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   en_i       run enable; low holds state and forces the output off
//   step_i     fade step strobe (coincides with the PWM wrap edge)
//   mode_i     fade pattern
//   pwm_cnt_i  shared PWM counter
//   led_o      registered PWM output
module fade_channel
    import pwm_fade_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP         = 12,
    parameter int W            = 11,
    parameter int INIT_DUTY    = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         step_i,
    input  fade_mode_t   mode_i,
    input  logic [W-1:0] pwm_cnt_i,
    output logic         led_o
);

    localparam logic [W-1:0] MAX_D  = W'(PWM_INTERVAL);
    localparam logic [W-1:0] STEP_D = W'(STEP);
    localparam logic [W-1:0] INIT_D = W'(INIT_DUTY);
    localparam logic [W-1:0] ZERO_D = {W{1'b0}};

    logic [W-1:0] duty_q;
    fade_dir_t    dir_q;
    logic [W-1:0] eff_duty_s;
    logic         led_q;

    // Duty/direction FSM: advances only on fade steps; the turn-around
    // direction is decided on the step that reaches an end point.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            duty_q <= INIT_D;
            dir_q  <= UP;
        end else if (step_i) begin
            case (mode_i)
                FADE_TRI: begin
                    if (dir_q == UP) begin
                        // Sitting at the top while UP happens after leaving sawtooth.
                        if (duty_q >= MAX_D) begin
                            duty_q <= duty_q - STEP_D;
                            dir_q  <= DOWN;
                        end else begin
                            duty_q <= duty_q + STEP_D;
                            dir_q  <= (duty_q == MAX_D - STEP_D) ? DOWN : UP;
                        end
                    end else begin
                        if (duty_q == ZERO_D) begin
                            duty_q <= duty_q + STEP_D;
                            dir_q  <= UP;
                        end else begin
                            duty_q <= duty_q - STEP_D;
                            dir_q  <= (duty_q == STEP_D) ? UP : DOWN;
                        end
                    end
                end
                FADE_SAW: begin
                    dir_q  <= UP;
                    duty_q <= (duty_q >= MAX_D) ? ZERO_D : duty_q + STEP_D;
                end
                default: begin
                    duty_q <= duty_q;
                    dir_q  <= dir_q;
                end
            endcase
        end else begin
            duty_q <= duty_q;
            dir_q  <= dir_q;
        end
    end

`ifdef FADE_GAMMA_EN
    localparam logic [2*W-1:0] MAX_WIDE = (2*W)'(PWM_INTERVAL);
    logic [2*W-1:0] sq_s;
    logic [2*W-1:0] quot_s;

    // Square-law mapping; duty <= PWM_INTERVAL keeps the quotient within W bits.
    always_comb begin
        sq_s       = {{W{1'b0}}, duty_q} * {{W{1'b0}}, duty_q};
        quot_s     = sq_s / MAX_WIDE;
        eff_duty_s = quot_s[W-1:0];
    end
`else
    // Linear mapping.
    always_comb begin
        eff_duty_s = duty_q;
    end
`endif

    // Registered compare: output for count k appears while the counter shows k+1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= 1'b0;
        end else begin
            led_q <= en_i && (pwm_cnt_i < eff_duty_s);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/pwm_fade_multi.sv
// Multi-channel breathing/sawtooth PWM LED fader with phase-spread channels.
// Optional feature macro: FADE_GAMMA_EN (square-law brightness per channel).
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           run enable; low freezes counters/duties and forces outputs off
//   mode         00 hold, 01 triangle, 10 sawtooth, 11 hold
//   LED          CHANNELS active-high PWM outputs
//   period_tick  one-cycle strobe in the first cycle of each PWM period
module pwm_fade_multi
    import pwm_fade_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP         = 12,
    parameter int FADE_DIV     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] LED,
    output logic                period_tick
);

    localparam int W  = $clog2(PWM_INTERVAL + 1);
    localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [W-1:0]  CNT_LAST = W'(PWM_INTERVAL - 1);
    localparam logic [W-1:0]  CNT_ONE  = W'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic [W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          period_tick_q;
    logic          wrap_s;
    logic          fade_step_s;
    fade_mode_t    mode_s;

    // Mode decode; the unused encoding behaves as hold.
    always_comb begin
        case (mode)
            2'b01:   mode_s = FADE_TRI;
            2'b10:   mode_s = FADE_SAW;
            default: mode_s = FADE_HOLD;
        endcase
    end

    // Shared counters: the period counter wraps, the divider counts wraps.
    always_comb begin
        wrap_s      = en && (pwm_cnt_q == CNT_LAST);
        fade_step_s = wrap_s && (div_cnt_q == DIV_LAST);
        if (!en) begin
            pwm_cnt_d = pwm_cnt_q;
        end else if (wrap_s) begin
            pwm_cnt_d = {W{1'b0}};
        end else begin
            pwm_cnt_d = pwm_cnt_q + CNT_ONE;
        end
        if (fade_step_s) begin
            div_cnt_d = {DW{1'b0}};
        end else if (wrap_s) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // Counter and period strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q     <= {W{1'b0}};
            div_cnt_q     <= {DW{1'b0}};
            period_tick_q <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            div_cnt_q     <= div_cnt_d;
            period_tick_q <= wrap_s;
        end
    end

    assign period_tick = period_tick_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        fade_channel #(
            .PWM_INTERVAL (PWM_INTERVAL),
            .STEP         (STEP),
            .W            (W),
            .INIT_DUTY    (init_duty(g, CHANNELS, PWM_INTERVAL, STEP))
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en),
            .step_i    (fade_step_s),
            .mode_i    (mode_s),
            .pwm_cnt_i (pwm_cnt_q),
            .led_o     (LED[g])
        );
    end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Self-checking bench for pwm_fade_multi (CHANNELS=3, PWM_INTERVAL=12, STEP=3,
// FADE_DIV=1). A period-level behavioural model is compared every cycle, and
// directed scenarios check hand-computed high-cycle counts per period.
module tb_pwm_fade_multi;

    localparam int CH = 3;
    localparam int PI = 12;
    localparam int ST = 3;
    localparam int FD = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CH-1:0] LED;
    logic          period_tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_fade_multi #(
        .CHANNELS     (CH),
        .PWM_INTERVAL (PI),
        .STEP         (ST),
        .FADE_DIV     (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .LED         (LED),
        .period_tick (period_tick)
    );

    // ---------------- behavioural model ----------------
    int            m_cnt;
    int            m_div;
    int            m_duty [CH];
    bit            m_down [CH];
    logic [CH-1:0] exp_led;
    logic          exp_tick;

    function automatic int eff(input int d);
`ifdef FADE_GAMMA_EN
        return (d * d) / PI;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_div = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = ((i * PI / CH) / ST) * ST;
            m_down[i] = 1'b0;
        end
        exp_led  = '0;
        exp_tick = 1'b0;
    endtask

    // Triangle modelled as reflection off 0 and PI; direction follows the motion.
    task automatic model_fade();
        int nd;
        for (int i = 0; i < CH; i++) begin
            case (mode)
                2'b01: begin
                    nd = m_duty[i] + (m_down[i] ? -ST : ST);
                    if (nd > PI) nd = 2 * PI - nd;
                    else if (nd < 0) nd = -nd;
                    if (nd == PI) m_down[i] = 1'b1;
                    else if (nd == 0) m_down[i] = 1'b0;
                    else m_down[i] = (nd < m_duty[i]);
                    m_duty[i] = nd;
                end
                2'b10: begin
                    m_duty[i] = (m_duty[i] >= PI) ? 0 : m_duty[i] + ST;
                    m_down[i] = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    // Predict the outputs produced by the coming clock edge.
    task automatic model_step();
        if (en) begin
            for (int i = 0; i < CH; i++) exp_led[i] = (m_cnt < eff(m_duty[i]));
            exp_tick = (m_cnt == PI - 1);
            if (m_cnt == PI - 1) begin
                m_cnt = 0;
                m_div++;
                if (m_div == FD) begin
                    m_div = 0;
                    model_fade();
                end
            end else begin
                m_cnt++;
            end
        end else begin
            exp_led  = '0;
            exp_tick = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            vectors++;
            if (LED !== exp_led || period_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t: LED=%b tick=%b, required LED=%b tick=%b",
                         $time, LED, period_tick, exp_led, exp_tick);
            end
            if (!rst) model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic sync_tick();
        bit found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (period_tick === 1'b1) found = 1'b1;
        end
        chk("sync_tick", int'(found), 1);
    endtask

    // Called on the negedge of a tick cycle; counts high cycles of one period.
    task automatic measure(output int hi [CH]);
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int n = 0; n < PI; n++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) hi[i] += int'(LED[i]);
        end
        chk("tick_spacing", int'(period_tick), 1);
    endtask

    task automatic do_reset(input logic [1:0] m);
        drive_edge();
        rst = 1'b1;
        drive_edge();
        rst  = 1'b0;
        mode = m;
        en   = 1'b1;
    endtask

    initial begin
        int hi [CH];
        int hold_exp [CH];
        int tri_seq [9];
        int saw_seq [4];
        int n;
        bit found;

        tri_seq = '{3, 6, 9, 12, 9, 6, 3, 0, 3};
        saw_seq = '{9, 12, 0, 3};
`ifdef FADE_GAMMA_EN
        hold_exp = '{0, 0, 3};
`else
        hold_exp = '{0, 3, 6};
`endif

        // Asynchronous reset, no clock edge yet.
        #1 rst = 1'b1;
        #1;
        chk("reset_led", int'(LED), 0);
        chk("reset_tick", int'(period_tick), 0);

        // HOLD with phase-spread duties.
        do_reset(2'b00);
        sync_tick();
        for (int p = 0; p < 2; p++) begin
            measure(hi);
            for (int i = 0; i < CH; i++) chk($sformatf("hold_ch%0d", i), hi[i], hold_exp[i]);
        end

        // TRIANGLE on ch0 from period 1 onward.
        do_reset(2'b01);
        sync_tick();
        for (int k = 0; k < 9; k++) begin
            measure(hi);
            chk($sformatf("tri_ch0_p%0d", k + 1), hi[0], eff(tri_seq[k]));
        end

        // SAWTOOTH on ch2 from period 1 onward.
        do_reset(2'b10);
        sync_tick();
        for (int k = 0; k < 4; k++) begin
            measure(hi);
            chk($sformatf("saw_ch2_p%0d", k + 1), hi[2], eff(saw_seq[k]));
        end

        // Sawtooth to triangle while ch2 sits at 12.
        do_reset(2'b10);
        sync_tick();
        measure(hi);
        chk("saw_ch2_p1", hi[2], eff(9));
        drive_edge();
        mode = 2'b01;
        sync_tick();
        measure(hi);
        chk("saw_to_tri_ch2", hi[2], eff(9));

        // Enable gap of 5 cycles at count 4.
        do_reset(2'b00);
        sync_tick();
        repeat (4) @(posedge clk);
        #2 en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            chk("gap_led", int'(LED), 0);
            chk("gap_tick", int'(period_tick), 0);
            if (k == 4) en = 1'b1;
        end
        n = 0;
        found = 1'b0;
        while (!found && n < 30) begin
            @(posedge clk);
            #2;
            n++;
            if (n == 1) chk("resume_led2", int'(LED[2]), (4 < eff(6)) ? 1 : 0);
            if (period_tick === 1'b1) found = 1'b1;
        end
        chk("resume_edges", n, 8);

        // Asynchronous reset mid-period while LED[2] is on.
        drive_edge();
        chk("pre_reset_led2", int'(LED[2]), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_led", int'(LED), 0);
        drive_edge();
        rst  = 1'b0;
        mode = 2'b00;
        sync_tick();
        measure(hi);
        for (int i = 0; i < CH; i++) chk($sformatf("post_reset_ch%0d", i), hi[i], hold_exp[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_fade_multi.md
# pwm_fade_multi

Multi-channel PWM LED fader: generates CHANNELS independent PWM outputs whose duty cycles ramp automatically in triangle (breathing) or sawtooth pattern, with evenly spaced phase offsets between channels. It sits directly under `top`, driving the board LEDs (e.g. RGB) from the system clock. It generalises the single-LED fade to N channels, runtime mode selection, enable/freeze and a period strobe.

## Interface
- `CHANNELS`, 3: number of PWM outputs (1–8).
- `PWM_INTERVAL`, 1200: clocks per PWM period; also the maximum duty value.
- `STEP`, 12: duty increment/decrement per fade step; `PWM_INTERVAL % STEP == 0` is required.
- `FADE_DIV`, 1: PWM periods per fade step (≥1).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; low freezes all counters and forces outputs off.
- `mode`  in  2  00 HOLD, 01 TRIANGLE, 10 SAWTOOTH, 11 treated as HOLD.
- `LED`  out  CHANNELS  PWM outputs, active-high.
- `period_tick`  out  1  one-cycle strobe at each PWM period start.

## Operation
- W = $clog2(PWM_INTERVAL+1). Duties are W-bit, range 0..PWM_INTERVAL, always multiples of STEP.
- `pwm_cnt` counts 0..PWM_INTERVAL-1 and wraps. Wrap edge = clock edge where `pwm_cnt == PWM_INTERVAL-1` and `en`=1.
- `div_cnt` counts wraps 0..FADE_DIV-1. Fade step = wrap edge with `div_cnt == FADE_DIV-1`.
- Per-channel state: `duty[i]`, `dir[i]` (UP/DOWN).
- Reset duty: `duty[i] = floor(i*PWM_INTERVAL/CHANNELS / STEP) * STEP`. `dir[i]` = UP.
- On each fade step, per channel:
  - HOLD: no change.
  - TRIANGLE: UP adds STEP. On reaching PWM_INTERVAL, dir becomes DOWN and the next step subtracts. DOWN subtracts STEP. On reaching 0, dir becomes UP. No overshoot, no saturation dwell beyond one step.
  - SAWTOOTH: dir forced UP. Adds STEP. From PWM_INTERVAL the next step loads 0.
- A mode change applies at the next fade step. Leaving SAWTOOTH for TRIANGLE resumes UP.
- Compare: `LED[i] <= en && (pwm_cnt < eff_duty[i])`.
  - duty 0: output always off.
  - duty PWM_INTERVAL: output always on.
- `en`=0:
  - `pwm_cnt`, `div_cnt`, duty and dir hold.
  - `LED` and `period_tick` are driven 0 on the next edge.
  - Resuming continues from the held `pwm_cnt`.

## Timing
- Reset values (asynchronous, immediate with no clock edge):
  - `LED` = 0, `period_tick` = 0.
  - `pwm_cnt` = 0, `div_cnt` = 0.
  - duty and dir as above.
- `period_tick <= en && pwm_cnt == PWM_INTERVAL-1`. It is high exactly in the cycle where `pwm_cnt` = 0 following a wrap.
- Duty updates occur on the wrap edge, so a new duty takes effect from `pwm_cnt` = 0. There are no mid-period glitches.
- `LED` is registered: the compare result for count k is visible during the cycle where `pwm_cnt` = k+1 (1-cycle latency).
- Reset asserted mid-period aborts the period. After release, counting starts at 0 on the first edge.

## Configuration
- `FADE_GAMMA_EN` defined: `eff_duty = (duty*duty) / PWM_INTERVAL`, truncated. The product is 2W bits wide. This gives perceptual square-law brightness. 0 and PWM_INTERVAL map to themselves.
- `FADE_GAMMA_EN` undefined: `eff_duty = duty` (linear). No multiplier is synthesised.

## Structure
- Package `pwm_fade_pkg` contains:
  - `fade_mode_t` enum: FADE_HOLD, FADE_TRI, FADE_SAW.
  - `fade_dir_t` enum: UP, DOWN.
  - Function `init_duty(i, CHANNELS, PWM_INTERVAL, STEP)`.
- Sub-module `fade_channel` holds duty/dir FSM, optional gamma and compare register. It is instantiated CHANNELS times in a generate loop.
- `pwm_cnt`, `div_cnt` and `period_tick` are shared in `pwm_fade_multi`.

## Test plan
Bench parameters: CHANNELS=3, PWM_INTERVAL=12, STEP=3, FADE_DIV=1, gamma off unless stated.
- Reset, then `en`=1, `mode`=HOLD. Required: reset duties 0/3/6. Per 12-cycle period, LED[0] high 0 cycles, LED[1] 3, LED[2] 6. `period_tick` pulses every 12 cycles.
- `mode`=TRIANGLE from reset. Required: ch0 duty sequence per period 0,3,6,9,12,9,6,3,0,3. In the duty-12 period, LED[0] is high all 12 cycles.
- `mode`=SAWTOOTH. Required: ch2 duty sequence 6,9,12,0,3. Switch to TRIANGLE while at 12: next step gives 9.
- Drop `en` for 5 cycles at `pwm_cnt`=4. Required: LED=000 and `period_tick`=0 during the gap. `pwm_cnt` resumes at 4, and the period completes 5 cycles later.
- Assert `rst` between clock edges mid-period with LED[2]=1. Required: LED=000 immediately, duties back to 0/3/6.
- `FADE_GAMMA_EN` defined, HOLD. Required: ch2 duty 6 gives 3 high cycles per period; ch1 duty 3 gives 0; duty 12 gives 12.
